// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, CMD, LEN, payload, XOR checksum.
// Payload is buffered and released on a valid/ready stream only after the checksum verifies.
module uart_rx_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] cmd,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    input  logic       pl_ready,
    output logic       pl_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {HUNT, S_CMD, S_LEN, S_PAY, S_CHK, DRAIN} state_t;

    state_t        state, state_d;
    logic [7:0]    cmd_r, len_r, chk;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    pl_buf [MAX_LEN];

    logic          in_frame, tmo_hit, rd_last, handshake;
    logic          ok_d, err_d;
    logic [1:0]    code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_d;
    end

    always_comb begin
        in_frame  = (state == S_CMD) || (state == S_LEN) || (state == S_PAY) || (state == S_CHK);
        // A byte in the expiry cycle clears the counter instead, so it wins over the timeout
        tmo_hit   = in_frame && !rx_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        rd_last   = (8'(rd_idx) == len_r - 8'd1);
        handshake = (state == DRAIN) && pl_ready;
        state_d   = state;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        code_d    = err_code;
        if (tmo_hit) begin
            state_d = HUNT;
            err_d   = 1'b1;
            code_d  = 2'd2;
        end else begin
            case (state)
                HUNT: if (rx_done && rx_data == SYNC_BYTE) state_d = S_CMD;
                S_CMD: if (rx_done) state_d = S_LEN;
                S_LEN: if (rx_done) begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else if (rx_data == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAY;
                    end
                end
                S_PAY: if (rx_done && 8'(wr_idx) == len_r - 8'd1) state_d = S_CHK;
                S_CHK: if (rx_done) begin
                    if (rx_data == chk) begin
                        ok_d    = 1'b1;
                        state_d = (len_r != 8'd0) ? DRAIN : HUNT;
                    end else begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                        code_d  = 2'd0;
                    end
                end
                DRAIN: begin
                    if (rx_done) begin
                        err_d  = 1'b1;
                        code_d = 2'd3;
                    end
                    if (handshake && rd_last) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign pl_valid = (state == DRAIN);
    assign pl_last  = pl_valid && rd_last;
    assign pl_data  = pl_buf[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= '0;
            cmd_r     <= '0;
            len_r     <= '0;
            chk       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            tmo_cnt   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            frame_ok  <= ok_d;
            frame_err <= err_d;
            err_code  <= code_d;
            if (!in_frame || rx_done || tmo_hit) tmo_cnt <= '0;
            else                                 tmo_cnt <= tmo_cnt + 1'b1;
            if (rx_done) begin
                case (state)
                    S_CMD: begin
                        cmd_r <= rx_data;
                        chk   <= rx_data;
                    end
                    S_LEN: begin
                        len_r  <= rx_data;
                        chk    <= chk ^ rx_data;
                        wr_idx <= '0;
                    end
                    S_PAY: begin
                        chk    <= chk ^ rx_data;
                        wr_idx <= wr_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (ok_d) begin
                cmd    <= cmd_r;
                rd_idx <= '0;
            end else if (handshake) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Payload storage deliberately has no reset
    always_ff @(posedge clk) begin
        if (state == S_PAY && rx_done) pl_buf[wr_idx] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_uart_rx_frame_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TMO     = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       pl_ready = 1'b0;
    logic [7:0] cmd, pl_data;
    logic       pl_valid, pl_last, frame_ok, frame_err;
    logic [1:0] err_code;

    uart_rx_frame_parser #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .cmd(cmd),
        .pl_data(pl_data),
        .pl_valid(pl_valid),
        .pl_ready(pl_ready),
        .pl_last(pl_last),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit is_err; logic [7:0] val; } ev_t;
    typedef struct { int cyc; logic [7:0] d; logic last; } pb_t;

    ev_t ev_q[$], exp_ev[$];
    pb_t pb_q[$], exp_pb[$];

    // Observed pulses and stream transfers, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_ok)  ev_q.push_back(ev_t'{cyc, 1'b0, cmd});
        if (frame_err) ev_q.push_back(ev_t'{cyc, 1'b1, {6'd0, err_code}});
        if (pl_valid && pl_ready) pb_q.push_back(pb_t'{cyc, pl_data, pl_last});
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_cmd = '0;
    logic [7:0] pay [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, output int at);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        at      = cyc;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic compare(input string tag);
        check({tag, ":ev_n"}, 32'(ev_q.size()), 32'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++) begin
            check({tag, ":ev_kind"}, 32'(ev_q[i].is_err), 32'(exp_ev[i].is_err));
            check({tag, ":ev_val"},  32'(ev_q[i].val),    32'(exp_ev[i].val));
            check({tag, ":ev_cyc"},  32'(ev_q[i].cyc),    32'(exp_ev[i].cyc));
        end
        check({tag, ":pl_n"}, 32'(pb_q.size()), 32'(exp_pb.size()));
        for (int i = 0; i < exp_pb.size() && i < pb_q.size(); i++) begin
            check({tag, ":pl_data"}, 32'(pb_q[i].d),    32'(exp_pb[i].d));
            check({tag, ":pl_last"}, 32'(pb_q[i].last), 32'(exp_pb[i].last));
            check({tag, ":pl_cyc"},  32'(pb_q[i].cyc),  32'(exp_pb[i].cyc));
        end
        ev_q.delete();
        pb_q.delete();
        exp_ev.delete();
        exp_pb.delete();
    endtask

    // Sends one frame (optionally preceded by junk) and predicts its outcome from the frame rules
    task automatic run_frame(input string tag, input int njunk, input logic [7:0] c,
                             input int len, input logic [7:0] corrupt);
        int t;
        logic [7:0] x;
        for (int i = 0; i < njunk; i++) begin
            do x = 8'($urandom); while (x == 8'hA5);
            send(x, t);
        end
        send(8'hA5, t);
        send(c, t);
        send(8'(len), t);
        if (len > int'(MAX_LEN)) begin
            exp_ev.push_back(ev_t'{t, 1'b1, 8'd1});
        end else begin
            x = c ^ 8'(len);
            for (int i = 0; i < len; i++) begin
                tick($urandom_range(0, 2));
                x ^= pay[i];
                send(pay[i], t);
            end
            send(x ^ corrupt, t);
            if (corrupt != 8'd0) begin
                exp_ev.push_back(ev_t'{t, 1'b1, 8'd0});
            end else begin
                exp_ev.push_back(ev_t'{t, 1'b0, c});
                exp_cmd = c;
                for (int i = 0; i < len; i++)
                    exp_pb.push_back(pb_t'{t + i, pay[i], (i == len - 1)});
            end
        end
        tick(len + 3);
        compare(tag);
        check({tag, ":cmd"}, 32'(cmd), 32'(exp_cmd));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":cmd"},       32'(cmd),       32'h0);
        check({tag, ":pl_valid"},  32'(pl_valid),  32'h0);
        check({tag, ":pl_last"},   32'(pl_last),   32'h0);
        check({tag, ":frame_ok"},  32'(frame_ok),  32'h0);
        check({tag, ":frame_err"}, 32'(frame_err), 32'h0);
        check({tag, ":err_code"},  32'(err_code),  32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t, t_ok, c0;
        logic [7:0] x;

        rst_n    = 1'b0;
        pl_ready = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Leading junk, then a 3-byte frame
        send(8'h00, t);
        send(8'hFF, t);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_frame("basic", 0, 8'h10, 3, 8'h00);

        run_frame("zero_len", 0, 8'h7E, 0, 8'h00);

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_frame("bad_chk", 0, 8'h10, 3, 8'h07);
        pay[0] = 8'h5A; pay[1] = 8'hA5;
        run_frame("after_bad", 0, 8'h42, 2, 8'h00);

        run_frame("too_long", 0, 8'h10, 17, 8'h00);
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
        run_frame("max_len", 0, 8'h33, 16, 8'h00);

        // Inter-byte timeout
        send(8'hA5, t); send(8'h10, t); send(8'h02, t); send(8'hAA, t);
        exp_ev.push_back(ev_t'{t + int'(TMO), 1'b1, 8'd2});
        tick(TMO + 5);
        compare("timeout");
        check("timeout:cmd", 32'(cmd), 32'(exp_cmd));

        // Byte landing exactly in the expiry cycle suppresses the timeout
        send(8'hA5, t); send(8'h10, t); send(8'h02, t); send(8'hAA, t);
        tick(TMO - 1);
        send(8'hBB, t);
        x = 8'h10 ^ 8'h02 ^ 8'hAA ^ 8'hBB;
        send(x, t);
        exp_ev.push_back(ev_t'{t, 1'b0, 8'h10});
        exp_pb.push_back(pb_t'{t, 8'hAA, 1'b0});
        exp_pb.push_back(pb_t'{t + 1, 8'hBB, 1'b1});
        exp_cmd = 8'h10;
        tick(5);
        compare("tmo_edge");

        // Overrun while the sink stalls
        pl_ready = 1'b0;
        send(8'hA5, t); send(8'h10, t); send(8'h03, t);
        send(8'h11, t); send(8'h22, t); send(8'h33, t);
        send(8'h13, t_ok);
        exp_ev.push_back(ev_t'{t_ok, 1'b0, 8'h10});
        tick(1);
        send(8'hA5, t);
        exp_ev.push_back(ev_t'{t, 1'b1, 8'd3});
        check("ovr:pl_data1", 32'(pl_data), 32'h11);
        tick(2);
        send(8'h55, t);
        exp_ev.push_back(ev_t'{t, 1'b1, 8'd3});
        tick(2);
        check("ovr:pl_valid", 32'(pl_valid), 32'h1);
        check("ovr:pl_data2", 32'(pl_data),  32'h11);
        check("ovr:pl_last",  32'(pl_last),  32'h0);
        pl_ready = 1'b1;
        c0 = cyc;
        exp_pb.push_back(pb_t'{c0,     8'h11, 1'b0});
        exp_pb.push_back(pb_t'{c0 + 1, 8'h22, 1'b0});
        exp_pb.push_back(pb_t'{c0 + 2, 8'h33, 1'b1});
        tick(5);
        compare("overrun");
        check("overrun:cmd", 32'(cmd), 32'h10);

        // Reset in the middle of a payload
        send(8'hA5, t); send(8'h5C, t); send(8'h03, t); send(8'h11, t);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick(2);
        rst_n   = 1'b1;
        exp_cmd = 8'h00;
        tick(TMO + 5);
        compare("rst_quiet");
        pay[0] = 8'h01;
        run_frame("after_rst", 0, 8'h66, 1, 8'h00);

        // Random frames
        for (int n = 0; n < 25; n++) begin
            int len;
            logic [7:0] corrupt;
            len = int'($urandom_range(0, 18));
            for (int i = 0; i < 32; i++) pay[i] = 8'($urandom);
            corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame("rand", int'($urandom_range(0, 2)), 8'($urandom), len, corrupt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Byte-level frame parser sitting directly downstream of the UART receiver. Consumes its `data`/`done` byte strobe, hunts for a sync byte, and captures command, length, payload and XOR checksum. Buffers the payload internally and releases it on a valid/ready stream only after the checksum verifies. Bad, oversized, stalled or overrun frames are reported with a one-cycle error pulse and code.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `MAX_LEN`, 16, maximum payload length in bytes (1..255).
- `TIMEOUT_CYCLES`, 1_000_000, maximum clk cycles between consecutive bytes inside a frame.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_done`=1.
- `rx_done`  in  1  one-cycle byte strobe from the UART receiver.
- `cmd`  out  8  command byte of the last accepted frame.
- `pl_data`  out  8  payload byte at the stream head.
- `pl_valid`  out  1  payload byte available.
- `pl_ready`  in  1  sink accepts `pl_data` when `pl_valid & pl_ready`.
- `pl_last`  out  1  marks the final payload byte.
- `frame_ok`  out  1  one-cycle pulse: frame accepted.
- `frame_err`  out  1  one-cycle pulse: frame or byte rejected.
- `err_code`  out  2  cause, valid with `frame_err`: 0 = checksum, 1 = length > MAX_LEN, 2 = timeout, 3 = overrun.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.
- Bytes are processed only on cycles with `rx_done`=1.
- States and transitions:
  - HUNT: byte == SYNC_BYTE -> S_CMD. Any other byte is silently dropped.
  - S_CMD: latch `cmd_r`; `chk` = byte -> S_LEN.
  - S_LEN: byte > MAX_LEN -> error code 1, HUNT. Otherwise `len_r` = byte, `chk` ^= byte, `wr_idx` = 0; go to S_CHK if byte == 0, else S_PAY.
  - S_PAY: `buf[wr_idx]` = byte, `chk` ^= byte, `wr_idx`++. Go to S_CHK when `wr_idx` == `len_r`-1.
  - S_CHK: byte == `chk` -> pulse `frame_ok`, copy `cmd_r` to `cmd`, `rd_idx` = 0; go to DRAIN if `len_r` > 0, else HUNT. byte != `chk` -> error code 0, HUNT.
  - DRAIN: `pl_valid`=1, `pl_data`=`buf[rd_idx]`, `pl_last` = (`rd_idx` == `len_r`-1). On handshake, `rd_idx`++; handshake with `pl_last` -> HUNT.
- Overrun: an `rx_done` while in DRAIN discards the byte and pulses `frame_err` with code 3. Drain continues unaffected. A SYNC byte arriving during DRAIN is also lost.
- Timeout: a counter clears on every `rx_done` and counts clk cycles in S_CMD, S_LEN, S_PAY and S_CHK. When it reaches TIMEOUT_CYCLES-1 without a byte: error code 2, HUNT. The counter is held at 0 in HUNT and DRAIN.
- `cmd` changes only on `frame_ok`. A rejected frame never disturbs `cmd` or any stream already in progress.
- The buffer is MAX_LEN x 8 registers and is not cleared by reset or errors.

## Timing
- Reset values: `cmd`=0, `pl_valid`=0, `pl_last`=0, `pl_data`=don't-care (buffer is uninitialised), `frame_ok`=0, `frame_err`=0, `err_code`=0, state HUNT, all counters 0.
- Reset asserted mid-frame or mid-drain: immediate return to HUNT with the values above. The partial frame is lost and no error pulse is issued.
- `frame_ok` and `frame_err` are registered and pulse exactly one cycle after the `rx_done` carrying the deciding byte. A timeout `frame_err` pulses one cycle after the count expires.
- `pl_valid` first rises in the same cycle as `frame_ok`. `pl_data`, `pl_valid` and `pl_last` are decoded from state and `rd_idx`.
- Throughput in DRAIN is one byte per cycle with `pl_ready` held high. `pl_valid` stays high and `pl_data` stays stable while `pl_ready`=0.
- `rx_done` and timeout expiry in the same cycle: the byte wins and no timeout is raised.
- `err_code` holds its last value between pulses.

## Test plan
- Bytes 00 FF A5 10 03 11 22 33 13 with `pl_ready`=1 -> leading junk ignored, one `frame_ok`, `cmd`=0x10, stream 11, 22, 33 on consecutive cycles, `pl_last` on 33, then HUNT.
- A5 7E 00 7E -> `frame_ok`, `cmd`=0x7E, `pl_valid` never asserts.
- A5 10 03 11 22 33 14 -> `frame_err` with code 0, no `pl_valid`, `cmd` unchanged. A following valid frame is accepted.
- A5 10 11 -> `frame_err` with code 1 one cycle after the 0x11 byte. The next A5 starts a fresh frame.
- A5 10 02 AA, then no bytes for TIMEOUT_CYCLES (bench parameter 50) -> `frame_err` with code 2. A byte arriving in the expiry cycle suppresses the timeout.
- Valid 3-byte frame with `pl_ready`=0 and two further bytes received -> two code-3 pulses, `pl_data`=0x11 held stable. Raising `pl_ready` drains 11, 22, 33 intact. Also assert `rst_n`=0 mid-payload -> all outputs return to reset values.
